packet_gen: RTL and testbench

PACKET_GEN -- requirements
Module: packet_gen

---
 rtl/packet_gen_pkg.sv | 51 +++++
 rtl/packet_gen_fifo.sv | 51 +++++
 rtl/packet_gen.sv | 137 +++++++++++++
 tb/tb_packet_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_gen_pkg.sv
// Shared definitions for the packet generator: header layout, request format,
// destination MAC table, FSM state encoding and the payload LFSR step.
package packet_gen_pkg;

    localparam int PORT_W = 2;
    localparam int LEN_W  = 6;
    localparam int REQ_W  = PORT_W + LEN_W;
    localparam int CNT_W  = 9;

    localparam int HDR_LEN_LSB = 21;
    localparam int HDR_LEN_MSB = HDR_LEN_LSB + LEN_W - 1;
    localparam int HDR_MAC_MSB = 15;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // The low byte of each address is the egress port the downstream switch decodes.
    localparam logic [3:0][47:0] MAC_TABLE = {
        48'h02A3_C0A8_0003,
        48'h02A2_C0A8_0002,
        48'h02A1_C0A8_0001,
        48'h02A0_C0A8_0000
    };

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR0    = 3'd1;
    localparam state_t ST_HDR1    = 3'd2;
    localparam state_t ST_HDR2    = 3'd3;
    localparam state_t ST_PAYLOAD = 3'd4;
    localparam state_t ST_GAP     = 3'd5;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [LEN_W-1:0]  len;
    } req_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] hdr0_word(input req_t req);
        logic [47:0] mac;
        logic [31:0] word;
        mac = MAC_TABLE[req.port];
        word = 32'h0;
        word[HDR_LEN_MSB:HDR_LEN_LSB] = req.len;
        word[HDR_MAC_MSB:0] = mac[47:32];
        return word;
    endfunction

endpackage

// File: rtl/packet_gen_fifo.sv
// Synchronous first-word-fall-through FIFO used to queue packet requests.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_gen.sv
// Packet generator: queues {port, len} requests and emits header plus LFSR
// payload words as one contiguous burst per packet, with optional idle gaps.
module packet_gen
    import packet_gen_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_port,
    input  logic [5:0]  req_len,
    input  logic [7:0]  gap_cycles,
    output logic [31:0] packet_out,
    output logic        packet_en,
    output logic        busy,
    output logic [15:0] pkt_sent
);

    state_t             state;
    req_t               cur;
    req_t               push_req;
    req_t               head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               last_word;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   last_cnt;
    logic [7:0]         gap_cnt;
    logic [31:0]        lfsr;
    logic [47:0]        cur_mac;

    assign push_req.port = req_port;
    assign push_req.len  = (req_len == '0) ? LEN_W'(1) : req_len;
    assign req_ready     = !fifo_full;
    assign busy          = (state != ST_IDLE) || !fifo_empty;
    assign cur_mac       = MAC_TABLE[cur.port];
    assign last_cnt      = {cur.len, 3'b000} - CNT_W'(1);
    assign last_word     = (state == ST_PAYLOAD) && (word_cnt == last_cnt);

    // A new packet starts from IDLE, straight after a gap-free packet, or at the end of a gap.
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) ||
                  (last_word && gap_cycles == 8'd0) ||
                  (state == ST_GAP && gap_cnt == 8'd1));

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Each branch loads the word for the state being entered, so output and state align.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur        <= '0;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            lfsr       <= LFSR_SEED;
            pkt_sent   <= '0;
            packet_out <= '0;
            packet_en  <= 1'b0;
        end else begin
            packet_en  <= 1'b0;
            packet_out <= '0;
            case (state)
                ST_IDLE: begin
                end
                ST_HDR0: begin
                    state      <= ST_HDR1;
                    word_cnt   <= CNT_W'(1);
                    packet_en  <= 1'b1;
                    packet_out <= cur_mac[31:0];
                end
                ST_HDR1: begin
                    state      <= ST_HDR2;
                    word_cnt   <= CNT_W'(2);
                    packet_en  <= 1'b1;
                end
                ST_HDR2: begin
                    state      <= ST_PAYLOAD;
                    word_cnt   <= CNT_W'(3);
                    packet_en  <= 1'b1;
                    packet_out <= lfsr;
                    lfsr       <= lfsr_next(lfsr);
                end
                ST_PAYLOAD: begin
                    if (last_word) begin
                        pkt_sent <= pkt_sent + 16'd1;
                        if (gap_cycles != 8'd0) begin
                            state   <= ST_GAP;
                            gap_cnt <= gap_cycles;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        word_cnt   <= word_cnt + CNT_W'(1);
                        packet_en  <= 1'b1;
                        packet_out <= lfsr;
                        lfsr       <= lfsr_next(lfsr);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (pop) begin
                cur        <= head;
                state      <= ST_HDR0;
                word_cnt   <= '0;
                packet_en  <= 1'b1;
                packet_out <= hdr0_word(head);
            end
        end
    end

endmodule

// File: tb/tb_packet_gen.sv
// Self-checking bench for packet_gen: directed scenarios plus randomized
// requests, checked word by word against a queue-based packet model.
module tb_packet_gen;

    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_port = 2'd0;
    logic [5:0]  req_len = 6'd0;
    logic [7:0]  gap_cycles = 8'd0;
    logic [31:0] packet_out;
    logic        packet_en;
    logic        busy;
    logic [15:0] pkt_sent;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_lfsr = SEED;
    int          model_sent = 0;
    bit          en_hist[$];
    int          runs[$];

    always #5 clk = ~clk;

    packet_gen #(
        .FIFO_DEPTH (4),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_port   (req_port),
        .req_len    (req_len),
        .gap_cycles (gap_cycles),
        .packet_out (packet_out),
        .packet_en  (packet_en),
        .busy       (busy),
        .pkt_sent   (pkt_sent)
    );

    function automatic logic [47:0] mac_of(input logic [1:0] p);
        case (p)
            2'd0:    return 48'h02A0_C0A8_0000;
            2'd1:    return 48'h02A1_C0A8_0001;
            2'd2:    return 48'h02A2_C0A8_0002;
            default: return 48'h02A3_C0A8_0003;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected words of one packet, appended in the order requests are accepted.
    task automatic model_packet(input logic [1:0] p, input logic [5:0] l);
        int          n;
        logic [47:0] m;
        n = (l == 6'd0) ? 1 : int'(l);
        m = mac_of(p);
        exp_q.push_back({5'd0, 6'(n), 5'd0, m[47:32]});
        exp_q.push_back(m[31:0]);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 8 * n - 3; i++) begin
            exp_q.push_back(model_lfsr);
            model_lfsr = model_lfsr[0] ? ((model_lfsr >> 1) ^ TAPS) : (model_lfsr >> 1);
        end
        model_sent++;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            en_hist.push_back(packet_en);
            if (packet_en) begin
                if (exp_q.size() == 0) begin
                    check("word_without_request", {31'd0, packet_en}, 32'd0);
                end else begin
                    check("word", packet_out, exp_q.pop_front());
                end
            end else begin
                check("idle_out_zero", packet_out, 32'd0);
            end
        end
    end

    task automatic push_req(input logic [1:0] p, input logic [5:0] l);
        int t;
        t = 0;
        @(negedge clk);
        req_port  = p;
        req_len   = l;
        req_valid = 1'b1;
        while (!req_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("push_accept_in_time", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        model_packet(p, l);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 3000);
        @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("words_drained", exp_q.size(), 32'd0);
    endtask

    // Lengths of alternating packet_en runs, starting at the first high sample.
    task automatic compute_runs();
        int i;
        int c;
        bit v;
        i = 0;
        runs.delete();
        while (i < en_hist.size() && en_hist[i] == 1'b0) i++;
        while (i < en_hist.size()) begin
            v = en_hist[i];
            c = 0;
            while (i < en_hist.size() && en_hist[i] == v) begin
                c++;
                i++;
            end
            if (v || i < en_hist.size()) runs.push_back(c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_packet_en", {31'd0, packet_en}, 32'd0);
        check("rst_packet_out", packet_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pkt_sent", {16'd0, pkt_sent}, 32'd0);
        reset = 1'b0;

        $display("[TB] single len-1 packet to port 2");
        gap_cycles = 8'd0;
        en_hist.delete();
        push_req(2'd2, 6'd1);
        wait_idle();
        compute_runs();
        check("p2_runs", runs.size(), 32'd1);
        check("p2_words", runs[0], 32'd8);
        check("p2_pkt_sent", {16'd0, pkt_sent}, 32'd1);

        $display("[TB] len 0 clamps to 1");
        en_hist.delete();
        push_req(2'd0, 6'd0);
        wait_idle();
        compute_runs();
        check("len0_runs", runs.size(), 32'd1);
        check("len0_words", runs[0], 32'd8);

        $display("[TB] two len-2 packets with gap 3");
        gap_cycles = 8'd3;
        en_hist.delete();
        push_req(2'd2, 6'd2);
        push_req(2'd1, 6'd2);
        wait_idle();
        compute_runs();
        check("gap_runs", runs.size(), 32'd3);
        check("gap_first", runs[0], 32'd16);
        check("gap_idle", runs[1], 32'd3);
        check("gap_second", runs[2], 32'd16);
        gap_cycles = 8'd0;

        $display("[TB] FIFO backpressure behind a len-63 packet");
        push_req(2'd1, 6'd63);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) push_req(2'($urandom_range(0, 3)), 6'd1);
        @(negedge clk);
        check("full_not_ready", {31'd0, req_ready}, 32'd0);
        req_port  = 2'd3;
        req_len   = 6'd1;
        req_valid = 1'b1;
        repeat (50) @(negedge clk);
        check("held_not_ready", {31'd0, req_ready}, 32'd0);
        check("long_streaming", {31'd0, packet_en}, 32'd1);
        push_req(2'd3, 6'd1);
        wait_idle();
        check("bp_pkt_sent", {16'd0, pkt_sent}, 32'(model_sent));

        $display("[TB] reset in the middle of a len-4 packet");
        push_req(2'd1, 6'd4);
        n = 0;
        t = 0;
        while (n < 11 && t < 500) begin
            @(negedge clk);
            if (packet_en) n++;
            t++;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_packet_en", {31'd0, packet_en}, 32'd0);
        check("abort_packet_out", packet_out, 32'd0);
        check("abort_pkt_sent", {16'd0, pkt_sent}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        exp_q.delete();
        model_lfsr = SEED;
        model_sent = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_abort_quiet", {31'd0, packet_en}, 32'd0);
        push_req(2'd3, 6'd1);
        wait_idle();
        check("post_abort_sent", {16'd0, pkt_sent}, 32'd1);

        $display("[TB] randomized requests");
        for (int g = 0; g < 3; g++) begin
            gap_cycles = 8'($urandom_range(0, 3));
            for (int k = 0; k < 8; k++) begin
                push_req(2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
            wait_idle();
            check("rand_pkt_sent", {16'd0, pkt_sent}, 32'(model_sent[15:0]));
        end
        gap_cycles = 8'd0;

        $display("[TB] pkt_sent wrap");
        force dut.pkt_sent = 16'hFFFE;
        @(negedge clk);
        release dut.pkt_sent;
        @(negedge clk);
        push_req(2'd0, 6'd1);
        wait_idle();
        check("wrap_ffff", {16'd0, pkt_sent}, 32'h0000_FFFF);
        push_req(2'd1, 6'd1);
        wait_idle();
        check("wrap_zero", {16'd0, pkt_sent}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
